instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
Writer side of the instruction memory. The control path fetches and decodes from this memory; this block fills it before the core runs. It receives a byte stream over a valid/ready handshake, reads a 16-bit word-count header, and assembles the payload into little-endian 32-bit instructions. Each instruction is written to consecutive word-aligned addresses from 0, and the core is held off fetching while the load is in progress.

Parameters:
ADDR_WIDTH, 12, byte address width of instruction memory (PC width); capacity = 2^ADDR_WIDTH/4 words
DATA_WIDTH, 32, instruction width; fixed at 32 (4 bytes per word)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  single-cycle pulse; begins a load; honoured only in IDLE
in_valid  input  1  in_data holds a valid byte
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle
we  output  1  instruction memory write enable
waddr  output  ADDR_WIDTH  byte address of write; always word aligned (low 2 bits 0)
wdata  output  DATA_WIDTH  assembled instruction
cpu_hold  output  1  high while loading; the core must not fetch or retire
done  output  1  one-cycle pulse on successful completion
error  output  1  sticky; header word count exceeds capacity

Behaviour:
- A byte transfers only on a cycle where in_valid && in_ready. No other cycle consumes a byte.
- Reset values: in_ready=0, we=0, waddr=0, wdata=0, cpu_hold=0, done=0, error=0. State=IDLE, word index=0, byte index=0.
- States and transitions:
  - IDLE: in_ready=0. On start: cpu_hold=1, error cleared, state → LEN_LO.
  - LEN_LO: in_ready=1. On transfer, count[7:0]=in_data, state → LEN_HI.
  - LEN_HI: in_ready=1. On transfer, count[15:8]=in_data.
    - count > capacity → ERROR.
    - count == 0 → DONE.
    - otherwise → DATA.
  - DATA: in_ready=1. Byte k (0..3) goes to word bits [8k+7:8k], so the first byte is the LSB. On the 4th transfer, state → WRITE.
  - WRITE: exactly one cycle. in_ready=0, we=1, waddr=word_index*4, wdata=assembled word. Word index then increments.
    - new index == count → DONE.
    - else → DATA with byte index=0.
  - DONE: one cycle. done=1 and cpu_hold=0 are registered in this state. State → IDLE.
  - ERROR: in_ready=0, cpu_hold=0, error=1. No writes. State → IDLE. error stays high until the next accepted start or rst.
- Latency: 4th payload byte accepted in cycle N → we=1 in cycle N+1.
- Throughput: minimum 5 cycles per word (4 transfers + 1 write cycle).
- we is high only in WRITE. waddr and wdata hold their last values otherwise.
- start is ignored outside IDLE.
- start and in_valid asserted in the same IDLE cycle: no byte is consumed, because in_ready=0 in IDLE.
- Stall: in_valid=0 mid-word holds state, partial word and byte index indefinitely.
- Capacity boundary: count == capacity (1024 at default) is legal. The last waddr is 0xFFC, and no address wrap occurs.
- count is 16 bits. Values above capacity always take the ERROR path; memory is never written in that case.
- rst mid-load: the return to reset values is immediate. Words already written stay in memory, so a partial image is possible. cpu_hold drops, and no done is produced.

Test Plan:
- Load 2 words: start, then bytes 02 00 | 13 05 A0 00 | 93 05 B0 00 → we pulses twice: (waddr 0x000, wdata 0x00A00513) and (0x004, 0x00B00593). done pulses once after the second write. cpu_hold is high from the cycle after start until done.
- Empty image: header 00 00 → no we. done pulses 1 cycle after the header's high byte. error=0.
- Overflow: header 01 04 (count 0x0401) → error=1, no we, in_ready=0. Stays sticky; the next start clears it.
- Capacity: count 0x0400, with each word equal to its index → 1024 writes. The last is waddr 0xFFC, wdata 0x000003FF. done fires and no write wraps to 0x000.
- Backpressure/stall: in_valid is toggled randomly and start is pulsed mid-load → the same writes as the unstalled run. start is ignored, and no byte is lost or duplicated.
- Reset mid-word: rst after 2 payload bytes of word 1 → all outputs return to reset values next cycle. A fresh load of 01 00 EF BE AD DE then writes 0xDEADBEEF at 0x000.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: byte stream in, instruction memory write port out
interface instr_mem_loader_if #(parameter int ADDR_WIDTH = 12, parameter int DATA_WIDTH = 32);
  logic in_valid;
  logic [7:0] in_data;
  logic in_ready;
  logic we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  modport master(input in_valid, in_data, output in_ready, we, waddr, wdata);
  modport slave(output in_valid, in_data, input in_ready, we, waddr, wdata);
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: fills instruction memory from a length-prefixed byte stream, holding the core off meanwhile
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  instr_mem_loader_if.master bus,
  output logic o_cpu_hold,
  output logic o_done,
  output logic o_error
);
  typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERROR} state_t;
  localparam logic [16:0] CAP = 17'(1) << (ADDR_WIDTH - 2);
  state_t r_state, w_next;
  logic [7:0] r_cnt_lo;
  logic [15:0] r_count;
  logic [16:0] r_widx;
  logic [1:0] r_bidx;
  logic [23:0] r_word;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic r_error;
  logic w_xfer;
  logic [15:0] w_count;
  logic [16:0] w_widx_nxt;
  assign w_xfer = bus.in_valid && bus.in_ready;
  assign w_count = {bus.in_data, r_cnt_lo};
  assign w_widx_nxt = r_widx + 17'd1;
  always_ff @(posedge clk)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:   w_next = i_start ? S_LEN_LO : S_IDLE;
      S_LEN_LO: w_next = w_xfer ? S_LEN_HI : S_LEN_LO;
      S_LEN_HI: w_next = !w_xfer ? S_LEN_HI : {1'b0, w_count} > CAP ? S_ERROR :
                         w_count == 16'd0 ? S_DONE : S_DATA;
      S_DATA:   w_next = (w_xfer && r_bidx == 2'd3) ? S_WRITE : S_DATA;
      S_WRITE:  w_next = w_widx_nxt == {1'b0, r_count} ? S_DONE : S_DATA;
      default:  w_next = S_IDLE;
    endcase
  end
  always_comb begin
    bus.in_ready = r_state == S_LEN_LO || r_state == S_LEN_HI || r_state == S_DATA;
    bus.we = r_state == S_WRITE;
    bus.waddr = r_waddr;
    bus.wdata = r_wdata;
    o_cpu_hold = bus.in_ready || r_state == S_WRITE;
    o_done = r_state == S_DONE;
    o_error = r_error;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_cnt_lo <= '0;
      r_count <= '0;
      r_widx <= '0;
      r_bidx <= '0;
      r_word <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_error <= 1'b0;
    end else begin
      if (r_state == S_IDLE && i_start) begin
        r_error <= 1'b0;
        r_widx <= '0;
        r_bidx <= '0;
      end
      if (r_state == S_LEN_LO && w_xfer) r_cnt_lo <= bus.in_data;
      if (r_state == S_LEN_HI && w_xfer) begin
        r_count <= w_count;
        if ({1'b0, w_count} > CAP) r_error <= 1'b1;
      end
      // bytes shift in from the top so the first one ends up as the LSB
      if (r_state == S_DATA && w_xfer) begin
        r_bidx <= r_bidx + 2'd1;
        r_word <= {bus.in_data, r_word[23:8]};
        if (r_bidx == 2'd3) begin
          r_waddr <= {r_widx[ADDR_WIDTH-3:0], 2'b00};
          r_wdata <= {bus.in_data, r_word};
        end
      end
      if (r_state == S_WRITE) r_widx <= w_widx_nxt;
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed checks of header parsing, word assembly, stalls, overflow and reset
module tb_instr_mem_loader;
  logic clk = 0, rst = 1, start = 0;
  logic cpu_hold, done, error;
  int total = 0, bad = 0;
  int nw = 0, nd = 0;
  logic [11:0] wa [0:2047];
  logic [31:0] wd [0:2047];
  instr_mem_loader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus();
  instr_mem_loader #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_start(start), .bus(bus.master),
    .o_cpu_hold(cpu_hold), .o_done(done), .o_error(error)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.we && nw < 2048) begin
      wa[nw] = bus.waddr;
      wd[nw] = bus.wdata;
      nw = nw + 1;
    end
    if (done) nd = nd + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic send(input logic [7:0] b, input int gap, input bit kick);
    int n = 0;
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 0;
      start = kick && g == 0;
      @(negedge clk);
    end
    start = 0;
    bus.in_valid = 1;
    bus.in_data = b;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 0, 1);
    @(negedge clk);
    bus.in_valid = 0;
  endtask
  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
  endtask
  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_we"}, bus.we, 0);
    chk({tag, "_waddr"}, bus.waddr, 0);
    chk({tag, "_wdata"}, bus.wdata, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
  endtask
  logic [7:0] prog [0:9] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
  initial begin
    int base, dbase;
    logic [31:0] w;
    bus.in_valid = 0;
    bus.in_data = 0;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst = 0;
    @(negedge clk);
    // two-word load, no stalls
    base = nw; dbase = nd;
    pulse_start();
    chk("load_hold", cpu_hold, 1);
    chk("load_ready", bus.in_ready, 1);
    for (int i = 0; i < 10; i++) send(prog[i], 0, 0);
    chk("load_lat_we", bus.we, 1);
    chk("load_lat_waddr", bus.waddr, 32'h004);
    chk("load_lat_wdata", bus.wdata, 32'h00B00593);
    chk("load_hold_wr", cpu_hold, 1);
    @(negedge clk);
    chk("load_done", done, 1);
    chk("load_hold_off", cpu_hold, 0);
    @(negedge clk);
    chk("load_done_1cyc", done, 0);
    chk("load_we_off", bus.we, 0);
    chk("load_waddr_hold", bus.waddr, 32'h004);
    chk("load_nw", nw - base, 2);
    chk("load_a0", wa[base], 32'h000);
    chk("load_d0", wd[base], 32'h00A00513);
    chk("load_a1", wa[base+1], 32'h004);
    chk("load_d1", wd[base+1], 32'h00B00593);
    chk("load_nd", nd - dbase, 1);
    // empty image
    base = nw;
    pulse_start();
    send(8'h00, 0, 0);
    send(8'h00, 0, 0);
    chk("empty_done", done, 1);
    chk("empty_err", error, 0);
    chk("empty_hold", cpu_hold, 0);
    repeat (2) @(negedge clk);
    chk("empty_nw", nw - base, 0);
    // overflow header 0x0401
    base = nw;
    pulse_start();
    send(8'h01, 0, 0);
    send(8'h04, 0, 0);
    chk("ovf_err", error, 1);
    chk("ovf_ready", bus.in_ready, 0);
    chk("ovf_hold", cpu_hold, 0);
    repeat (3) @(negedge clk);
    chk("ovf_sticky", error, 1);
    chk("ovf_idle_ready", bus.in_ready, 0);
    chk("ovf_nw", nw - base, 0);
    pulse_start();
    chk("ovf_clear", error, 0);
    send(8'h00, 0, 0);
    send(8'h00, 0, 0);
    chk("ovf_recover_done", done, 1);
    @(negedge clk);
    // same image with stalls and stray start pulses
    base = nw; dbase = nd;
    pulse_start();
    for (int i = 0; i < 10; i++) send(prog[i], $urandom_range(0, 3) + ((i == 4 || i == 7) ? 1 : 0), i == 4 || i == 7);
    wait_done(10);
    repeat (2) @(negedge clk);
    chk("stall_nw", nw - base, 2);
    chk("stall_a0", wa[base], 32'h000);
    chk("stall_d0", wd[base], 32'h00A00513);
    chk("stall_a1", wa[base+1], 32'h004);
    chk("stall_d1", wd[base+1], 32'h00B00593);
    chk("stall_nd", nd - dbase, 1);
    // full capacity, word i holds i
    base = nw;
    pulse_start();
    send(8'h00, 0, 0);
    send(8'h04, 0, 0);
    for (int i = 0; i < 1024; i++) begin
      w = i;
      for (int k = 0; k < 4; k++) send(w[8*k +: 8], 0, 0);
    end
    wait_done(10);
    repeat (2) @(negedge clk);
    chk("cap_nw", nw - base, 1024);
    for (int i = 0; i < 1024; i++) begin
      chk("cap_addr", wa[base+i], i * 4);
      chk("cap_data", wd[base+i], i);
    end
    chk("cap_last_addr", wa[base+1023], 32'hFFC);
    chk("cap_err", error, 0);
    // reset after two bytes of the second word
    base = nw;
    pulse_start();
    send(8'h02, 0, 0);
    send(8'h00, 0, 0);
    send(8'h11, 0, 0);
    send(8'h22, 0, 0);
    send(8'h33, 0, 0);
    send(8'h44, 0, 0);
    send(8'h55, 0, 0);
    send(8'h66, 0, 0);
    dbase = nd;
    rst = 1;
    @(negedge clk);
    chk_reset_outs("midrst");
    rst = 0;
    @(negedge clk);
    chk("midrst_nw", nw - base, 1);
    chk("midrst_d0", wd[base], 32'h44332211);
    chk("midrst_nd", nd - dbase, 0);
    base = nw;
    pulse_start();
    send(8'h01, 0, 0);
    send(8'h00, 0, 0);
    send(8'hEF, 0, 0);
    send(8'hBE, 0, 0);
    send(8'hAD, 0, 0);
    send(8'hDE, 0, 0);
    wait_done(10);
    repeat (2) @(negedge clk);
    chk("fresh_nw", nw - base, 1);
    chk("fresh_a0", wa[base], 32'h000);
    chk("fresh_d0", wd[base], 32'hDEADBEEF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
